// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and data requesters, one transaction at a time,
// with round-robin tie breaking and an optional request/response timeout.
module mem_port_arbiter #(
    parameter int N       = 32,
    parameter int A       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [A-1:0] i_addr,
    output logic         i_ack,
    output logic         i_rvalid,
    output logic [N-1:0] i_rdata,
    output logic         i_err,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [A-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic         d_rvalid,
    output logic [N-1:0] d_rdata,
    output logic         d_err,
    output logic         proc_req,
    output logic         we,
    output logic [A-1:0] addr,
    output logic [N-1:0] wdata,
    input  logic         mem_rdy,
    input  logic         valid,
    input  logic [N-1:0] rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    state;
    logic          owner;
    logic          last_gnt;
    logic          we_r;
    logic [A-1:0]  addr_r;
    logic [N-1:0]  wdata_r;
    logic [CW-1:0] cnt;

    logic grant_d;
    logic grant_any;
    logic timeout_hit;
    logic accept;
    logic done_rd;
    logic abort;

    // Outputs are qualified with rst so an abandoned transaction shows nothing during reset.
    always_comb begin
        grant_d     = d_req && (!i_req || (last_gnt == OWN_I));
        grant_any   = i_req || d_req;
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
        accept      = rst && (state == REQ) && mem_rdy;
        done_rd     = rst && (state == WAIT) && valid;
        abort       = rst && timeout_hit &&
                      (((state == REQ) && !mem_rdy) || ((state == WAIT) && !valid));
    end

    always_comb begin
        proc_req = rst && (state == REQ);
        we       = proc_req ? we_r : 1'b0;
        addr     = proc_req ? addr_r : '0;
        wdata    = proc_req ? wdata_r : '0;
        i_ack    = accept && (owner == OWN_I);
        d_ack    = accept && (owner == OWN_D);
        i_rvalid = done_rd && (owner == OWN_I);
        d_rvalid = done_rd && (owner == OWN_D);
        i_rdata  = i_rvalid ? rdata : '0;
        d_rdata  = d_rvalid ? rdata : '0;
        i_err    = abort && (owner == OWN_I);
        d_err    = abort && (owner == OWN_D);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_I;
            last_gnt <= OWN_I;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= REQ;
                        cnt   <= '0;
                        if (grant_d) begin
                            owner   <= OWN_D;
                            addr_r  <= d_addr;
                            we_r    <= d_we;
                            wdata_r <= d_wdata;
                        end else begin
                            owner   <= OWN_I;
                            addr_r  <= i_addr;
                            we_r    <= 1'b0;
                            wdata_r <= '0;
                        end
                    end
                end
                REQ: begin
                    // Acceptance takes priority over a timeout expiring in the same cycle.
                    if (mem_rdy) begin
                        last_gnt <= owner;
                        cnt      <= '0;
                        state    <= we_r ? IDLE : WAIT;
                    end else if (abort) begin
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (valid || abort) begin
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for contention, timeouts, reset mid-read and timeout/acceptance races.
module tb_mem_port_arbiter;

    localparam int N   = 32;
    localparam int A   = 32;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req;
    logic [A-1:0] i_addr;
    logic         i_ack;
    logic         i_rvalid;
    logic [N-1:0] i_rdata;
    logic         i_err;
    logic         d_req;
    logic         d_we;
    logic [A-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic         d_ack;
    logic         d_rvalid;
    logic [N-1:0] d_rdata;
    logic         d_err;
    logic         proc_req;
    logic         we;
    logic [A-1:0] addr;
    logic [N-1:0] wdata;
    logic         mem_rdy;
    logic         valid;
    logic [N-1:0] rdata;

    mem_port_arbiter #(.N(N), .A(A), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .proc_req(proc_req), .we(we), .addr(addr), .wdata(wdata),
        .mem_rdy(mem_rdy), .valid(valid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_rdy;
        logic        valid;
        logic [31:0] rdata;
        logic [7:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic addVec(input string nm, input logic r, input logic ir, input logic [31:0] ia,
                          input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                          input logic mr, input logic vl, input logic [31:0] rd, input logic [7:0] c,
                          input logic [31:0] ea, input logic [31:0] ewd, input logic [31:0] eir,
                          input logic [31:0] edr);
        vec_t v;
        v.name = nm; v.rst = r; v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw;
        v.d_addr = da; v.d_wdata = dwd; v.mem_rdy = mr; v.valid = vl; v.rdata = rd;
        v.ctrl = c; v.addr = ea; v.wdata = ewd; v.irdata = eir; v.drdata = edr;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // {proc_req, we, i_ack, i_rvalid, i_err, d_ack, d_rvalid, d_err}
    function automatic logic [31:0] ctrlBits();
        return {24'b0, proc_req, we, i_ack, i_rvalid, i_err, d_ack, d_rvalid, d_err};
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; i_req = v.i_req; i_addr = v.i_addr; d_req = v.d_req; d_we = v.d_we;
        d_addr = v.d_addr; d_wdata = v.d_wdata; mem_rdy = v.mem_rdy; valid = v.valid; rdata = v.rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdy = 1'b0; valid = 1'b0; rdata = '0;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [7:0] order [4];
    int         grants;

    initial begin
        idleInputs();
        rst = 1'b0;
        tick();

        //      name          rst ir ia         dr dw da         dwd           mr vl rdata          ctrl          addr       wdata         irdata         drdata
        addVec("rst",         0,  0, 32'h0,     1, 0, 32'h0,     32'h0,        1, 1, 32'hFFFF,      8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("ld_idle",     1,  0, 32'h0,     1, 0, 32'h100,   32'h0,        0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("ld_req",      1,  0, 32'h0,     1, 0, 32'h100,   32'h0,        1, 0, 32'h0,         8'b1000_0100, 32'h100,   32'h0,        32'h0,         32'h0);
        addVec("ld_wait",     1,  0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("ld_valid",    1,  0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 1, 32'hDEADBEEF,  8'b0000_0010, 32'h0,     32'h0,        32'h0,         32'hDEADBEEF);
        addVec("idle_valid",  1,  0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 1, 32'h55,        8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("st_idle",     1,  0, 32'h0,     1, 1, 32'h200,   32'h12345678, 0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("st_stall0",   1,  0, 32'h0,     1, 1, 32'h200,   32'h12345678, 0, 0, 32'h0,         8'b1100_0000, 32'h200,   32'h12345678, 32'h0,         32'h0);
        addVec("st_stall1",   1,  0, 32'h0,     1, 1, 32'h200,   32'h12345678, 0, 1, 32'hBAD,       8'b1100_0000, 32'h200,   32'h12345678, 32'h0,         32'h0);
        addVec("st_stall2",   1,  0, 32'h0,     1, 1, 32'h200,   32'h12345678, 0, 0, 32'h0,         8'b1100_0000, 32'h200,   32'h12345678, 32'h0,         32'h0);
        addVec("st_ack",      1,  0, 32'h0,     1, 1, 32'h200,   32'h12345678, 1, 0, 32'h0,         8'b1100_0100, 32'h200,   32'h12345678, 32'h0,         32'h0);
        addVec("st_done",     1,  0, 32'h0,     0, 0, 32'h0,     32'h12345678, 0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("f_idle",      1,  1, 32'h40,    0, 0, 32'h0,     32'h12345678, 0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);
        addVec("f_req",       1,  1, 32'h40,    0, 0, 32'h0,     32'h12345678, 1, 0, 32'h0,         8'b1010_0000, 32'h40,    32'h0,        32'h0,         32'h0);
        addVec("f_valid",     1,  0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 1, 32'hCAFEF00D,  8'b0001_0000, 32'h0,     32'h0,        32'hCAFEF00D,  32'h0);
        addVec("f_done",      1,  0, 32'h0,     0, 0, 32'h0,     32'h0,        0, 0, 32'h0,         8'b0000_0000, 32'h0,     32'h0,        32'h0,         32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("%s.ctrl", vecs[i].name), ctrlBits(), {24'b0, vecs[i].ctrl});
            checkOutput($sformatf("%s.addr", vecs[i].name), addr, vecs[i].addr);
            checkOutput($sformatf("%s.wdata", vecs[i].name), wdata, vecs[i].wdata);
            checkOutput($sformatf("%s.i_rdata", vecs[i].name), i_rdata, vecs[i].irdata);
            checkOutput($sformatf("%s.d_rdata", vecs[i].name), d_rdata, vecs[i].drdata);
            tick();
        end

        // Contention: both requesters held high, grants must alternate starting with data.
        doReset();
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hA5A5;
        mem_rdy = 1'b1; valid = 1'b1; rdata = 32'h77;
        grants = 0;
        for (int k = 0; k < 4; k++) order[k] = 8'h2D;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) checkOutput("contend_single_ack", 32'd2, 32'd1);
            if (i_ack) begin
                checkOutput("contend_i_addr", addr, 32'h1000);
                order[grants] = "f";
                grants++;
            end else if (d_ack) begin
                checkOutput("contend_d_addr", addr, 32'h2000);
                order[grants] = "d";
                grants++;
            end
            tick();
        end
        checkOutput("contend_grants", grants, 32'd4);
        checkOutput("contend_g0", {24'b0, order[0]}, {24'b0, 8'h64});
        checkOutput("contend_g1", {24'b0, order[1]}, {24'b0, 8'h66});
        checkOutput("contend_g2", {24'b0, order[2]}, {24'b0, 8'h64});
        checkOutput("contend_g3", {24'b0, order[3]}, {24'b0, 8'h66});

        // WAIT timeout: load accepted, valid never arrives.
        doReset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        mem_rdy = 1'b1;
        @(negedge clk);
        checkOutput("to_ack", ctrlBits(), 32'b1000_0100);
        tick();
        d_req = 1'b0; mem_rdy = 1'b0; valid = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            checkOutput($sformatf("to_wait_c%0d", k), ctrlBits(), (k == TMO - 1) ? 32'b0000_0001 : 32'b0);
            tick();
        end
        valid = 1'b1; rdata = 32'h99;
        @(negedge clk);
        checkOutput("to_late_valid", ctrlBits(), 32'b0);
        checkOutput("to_late_rdata", d_rdata, 32'h0);
        tick();
        valid = 1'b0;

        // Reset while in WAIT, then a late valid after release.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        tick();
        mem_rdy = 1'b1;
        tick();
        d_req = 1'b0; mem_rdy = 1'b0;
        tick();
        rst = 1'b0; mem_rdy = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid", ctrlBits(), 32'b0);
        tick();
        rst = 1'b1; mem_rdy = 1'b0; valid = 1'b1; rdata = 32'hABCD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_late_valid%0d", k), ctrlBits(), 32'b0);
            tick();
        end
        valid = 1'b0;

        // Acceptance and response arriving exactly as the timeout would expire.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
        tick();
        for (int k = 0; k < TMO; k++) begin
            mem_rdy = (k == TMO - 1);
            @(negedge clk);
            checkOutput($sformatf("race_req_c%0d", k), ctrlBits(), (k == TMO - 1) ? 32'b1000_0100 : 32'b1000_0000);
            checkOutput($sformatf("race_req_addr%0d", k), addr, 32'h700);
            tick();
        end
        d_req = 1'b0; mem_rdy = 1'b0; rdata = 32'h1234;
        for (int k = 0; k < TMO; k++) begin
            valid = (k == TMO - 1);
            @(negedge clk);
            checkOutput($sformatf("race_wait_c%0d", k), ctrlBits(), (k == TMO - 1) ? 32'b0000_0010 : 32'b0);
            tick();
        end
        checkOutput("race_idle_pre", ctrlBits(), 32'b0);
        valid = 1'b0;

        // REQ timeout on a fetch; last_gnt must stay on data so fetch wins the next tie.
        i_req = 1'b1; i_addr = 32'h800;
        tick();
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (k == TMO - 1)
                checkOutput("reqto_err", ctrlBits() & 32'h3F, 32'b0000_1000);
            else
                checkOutput($sformatf("reqto_c%0d", k), ctrlBits(), 32'b1000_0000);
            tick();
        end
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("reqto_idle", ctrlBits(), 32'b0);
        tick();
        i_req = 1'b1; i_addr = 32'h900; d_req = 1'b1; d_we = 1'b1; d_addr = 32'hA00; mem_rdy = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("reqto_tie_ctrl", ctrlBits(), 32'b1010_0000);
        checkOutput("reqto_tie_addr", addr, 32'h900);
        tick();
        idleInputs();
        valid = 1'b1; rdata = 32'h4321;
        @(negedge clk);
        checkOutput("reqto_tie_rdata", i_rdata, 32'h4321);
        tick();
        valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
